// File: rtl/t02_pkg.sv
`default_nettype none
// ============================================================================
// Module : t02_pkg
// Brief  : Shared types and constants for the register-file write arbiter.
// Rev    : 1.0
// ============================================================================
package t02_pkg;

    typedef logic [4:0]  reg_idx_t;
    typedef logic [31:0] word_t;

    typedef enum logic [0:0] {
        NORMAL    = 1'b0,
        MEM_FORCE = 1'b1
    } arb_state_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

endpackage
`default_nettype wire

// File: rtl/t02_rf_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : t02_rf_write_arbiter_if
// Brief  : Writeback requests, decode lookup and register-file write bundle.
// Rev    : 1.0
// ============================================================================
interface t02_rf_write_arbiter_if;
    import t02_pkg::*;

    logic     alu_valid;
    reg_idx_t alu_rd;
    word_t    alu_data;
    logic     alu_ready;

    logic     mem_valid;
    reg_idx_t mem_rd;
    word_t    mem_data;
    logic     mem_ready;

    logic     issue_load;
    reg_idx_t issue_rd;
    reg_idx_t rs1;
    reg_idx_t rs2;
    logic     stall;

    logic     rf_reg_write;
    logic     rf_en;
    reg_idx_t rf_write_index;
    word_t    rf_write_data;
    logic     sb_err;

    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output mem_valid, mem_rd, mem_data,
        input  mem_ready,
        output issue_load, issue_rd, rs1, rs2,
        input  stall,
        input  rf_reg_write, rf_en, rf_write_index, rf_write_data, sb_err
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  mem_valid, mem_rd, mem_data,
        output mem_ready,
        input  issue_load, issue_rd, rs1, rs2,
        output stall,
        output rf_reg_write, rf_en, rf_write_index, rf_write_data, sb_err
    );

endinterface
`default_nettype wire

// File: rtl/t02_load_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : t02_load_scoreboard
// Brief  : Pending-load bit per register, protocol-error flag, operand hits.
// Rev    : 1.0
// ============================================================================
module t02_load_scoreboard
    import t02_pkg::*;
(
    input  wire logic     clk,
    input  wire logic     rst,
    input  wire logic     i_issue_load,
    input  wire reg_idx_t i_issue_rd,
    input  wire logic     i_clr,
    input  wire reg_idx_t i_clr_rd,
    input  wire reg_idx_t i_rs1,
    input  wire reg_idx_t i_rs2,
    input  wire logic     i_wr_inflight,
    input  wire reg_idx_t i_wr_index,
    output logic          o_stall,
    output logic          o_sb_err
);

    logic [31:1] r_pending;
    logic [31:1] w_pending_nxt;
    logic [31:0] w_pend_full;
    logic        r_sb_err;
    logic        w_set;
    logic        w_err_dup;
    logic        w_err_orphan;
    reg_idx_t    w_rs [2];
    logic [1:0]  w_hit;

    assign w_pend_full = {r_pending, 1'b0};
    assign w_set       = i_issue_load && (i_issue_rd != REG_ZERO);

    // Set is applied after clear so a same-cycle set/clear on one index keeps the bit.
    generate
        for (genvar i = 1; i < 32; i++) begin : g_pend_bit
            assign w_pending_nxt[i] = (w_set && (i_issue_rd == 5'(i)))
                                    | (r_pending[i] & ~(i_clr && (i_clr_rd == 5'(i))));
        end
    endgenerate

    assign w_err_dup    = w_set && w_pend_full[i_issue_rd]
                        && !(i_clr && (i_clr_rd == i_issue_rd));
    assign w_err_orphan = i_clr && !w_pend_full[i_clr_rd];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_sb_err  <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            r_sb_err  <= r_sb_err | w_err_dup | w_err_orphan;
        end
    end

    assign w_rs[0] = i_rs1;
    assign w_rs[1] = i_rs2;

    // A register still being written by the registered write port counts as busy.
    generate
        for (genvar k = 0; k < 2; k++) begin : g_rd_port
            assign w_hit[k] = (w_rs[k] != REG_ZERO)
                            && (w_pend_full[w_rs[k]]
                                || (i_wr_inflight && (i_wr_index == w_rs[k])));
        end
    endgenerate

    assign o_stall  = |w_hit;
    assign o_sb_err = r_sb_err;

endmodule
`default_nettype wire

// File: rtl/t02_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module : t02_rf_write_arbiter
// Brief  : Arbitrates ALU and load writebacks onto the single RF write port.
// Rev    : 1.0
// ============================================================================
module t02_rf_write_arbiter
    import t02_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
)(
    input  wire logic              clk,
    input  wire logic              rst,
    t02_rf_write_arbiter_if.slave  bus
);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_alu_grant;
    logic             w_mem_grant;
    reg_idx_t         w_win_rd;
    word_t            w_win_data;
    logic             r_rf_wr;
    reg_idx_t         r_rf_index;
    word_t            r_rf_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= NORMAL;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_alu_grant = 1'b0;
        w_mem_grant = 1'b0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_wait_cnt;
        case (r_state)
            NORMAL: begin
                if (bus.alu_valid) begin
                    w_alu_grant = 1'b1;
                end else if (bus.mem_valid) begin
                    w_mem_grant = 1'b1;
                end
                // Enter MEM_FORCE on the same edge the loss count hits the limit.
                if (bus.mem_valid && !w_mem_grant) begin
                    w_cnt_nxt = r_wait_cnt + 1'b1;
                    if (w_cnt_nxt >= CNT_W'(STARVE_LIMIT)) begin
                        w_state_nxt = MEM_FORCE;
                    end
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            MEM_FORCE: begin
                if (bus.mem_valid) begin
                    w_mem_grant = 1'b1;
                end else if (bus.alu_valid) begin
                    w_alu_grant = 1'b1;
                end
                w_state_nxt = NORMAL;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = NORMAL;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_win_rd   = bus.alu_rd;
        w_win_data = bus.alu_data;
        if (w_mem_grant) begin
            w_win_rd   = bus.mem_rd;
            w_win_data = bus.mem_data;
        end
    end

    // Index/data track every grant; the strobe is suppressed for x0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf_wr    <= 1'b0;
            r_rf_index <= REG_ZERO;
            r_rf_data  <= '0;
        end else if (w_alu_grant || w_mem_grant) begin
            r_rf_wr    <= (w_win_rd != REG_ZERO);
            r_rf_index <= w_win_rd;
            r_rf_data  <= w_win_data;
        end else begin
            r_rf_wr    <= 1'b0;
        end
    end

    t02_load_scoreboard u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .i_issue_load  (bus.issue_load),
        .i_issue_rd    (bus.issue_rd),
        .i_clr         (w_mem_grant),
        .i_clr_rd      (bus.mem_rd),
        .i_rs1         (bus.rs1),
        .i_rs2         (bus.rs2),
        .i_wr_inflight (r_rf_wr),
        .i_wr_index    (r_rf_index),
        .o_stall       (bus.stall),
        .o_sb_err      (bus.sb_err)
    );

    assign bus.alu_ready      = w_alu_grant;
    assign bus.mem_ready      = w_mem_grant;
    assign bus.rf_reg_write   = r_rf_wr;
    assign bus.rf_en          = r_rf_wr;
    assign bus.rf_write_index = r_rf_index;
    assign bus.rf_write_data  = r_rf_data;

endmodule
`default_nettype wire

// File: tb/tb_t02_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_t02_rf_write_arbiter
// Brief  : Scoreboard bench for the register-file write arbiter.
// Rev    : 1.0
// ============================================================================
module tb_t02_rf_write_arbiter;
    import t02_pkg::*;

    localparam int STARVE_LIMIT = 4;

    typedef struct packed {
        logic        we;
        logic [4:0]  idx;
        logic [31:0] data;
    } wr_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    t02_rf_write_arbiter_if bus();

    t02_rf_write_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    wr_exp_t     exp_q[$];

    // Reference model state
    logic        m_force = 1'b0;
    int          m_cnt   = 0;
    logic [31:0] m_pend  = '0;
    logic        m_err   = 1'b0;
    logic        m_we    = 1'b0;
    logic [4:0]  m_idx   = '0;
    logic [31:0] m_data  = '0;

    logic        last_alu_ready;
    logic        last_mem_ready;
    logic        last_stall;
    logic        last_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_hit(input logic [4:0] r);
        return (r != 5'd0) && (m_pend[r] || (m_we && (m_idx == r)));
    endfunction

    // One clock cycle: drive, check at negedge, advance model, return 1 after posedge.
    task automatic cyc(input logic r,
                       input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
                       input logic il, input logic [4:0] ird,
                       input logic [4:0] s1, input logic [4:0] s2);
        logic    ag, mg;
        wr_exp_t e;
        rst            = r;
        bus.alu_valid  = av;  bus.alu_rd = ard;  bus.alu_data = adat;
        bus.mem_valid  = mv;  bus.mem_rd = mrd;  bus.mem_data = mdat;
        bus.issue_load = il;  bus.issue_rd = ird;
        bus.rs1        = s1;  bus.rs2 = s2;
        @(negedge clk);

        ag = 1'b0;
        mg = 1'b0;
        if (m_force && mv)  mg = 1'b1;
        else if (av)        ag = 1'b1;
        else if (mv)        mg = 1'b1;

        chk("alu_ready", bus.alu_ready, ag);
        chk("mem_ready", bus.mem_ready, mg);
        chk("stall",     bus.stall,     m_hit(s1) | m_hit(s2));
        chk("sb_err",    bus.sb_err,    m_err);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rf_reg_write",   bus.rf_reg_write,   e.we);
            chk("rf_en",          bus.rf_en,          e.we);
            chk("rf_write_index", bus.rf_write_index, e.idx);
            chk("rf_write_data",  bus.rf_write_data,  e.data);
        end
        last_alu_ready = bus.alu_ready;
        last_mem_ready = bus.mem_ready;
        last_stall     = bus.stall;
        last_err       = bus.sb_err;

        if (r) begin
            m_force = 1'b0; m_cnt = 0; m_pend = '0; m_err = 1'b0;
            m_we = 1'b0; m_idx = '0; m_data = '0;
        end else begin
            if (ag) begin
                m_we = (ard != 5'd0); m_idx = ard; m_data = adat;
            end else if (mg) begin
                m_we = (mrd != 5'd0); m_idx = mrd; m_data = mdat;
            end else begin
                m_we = 1'b0;
            end
            if (il && ird != 5'd0 && m_pend[ird] && !(mg && mrd == ird)) m_err = 1'b1;
            if (mg && !m_pend[mrd]) m_err = 1'b1;
            if (mg) m_pend[mrd] = 1'b0;
            if (il && ird != 5'd0) m_pend[ird] = 1'b1;
            m_pend[0] = 1'b0;
            if (!m_force) begin
                if (mv && !mg) begin
                    m_cnt++;
                    if (m_cnt == STARVE_LIMIT) m_force = 1'b1;
                end else begin
                    m_cnt = 0;
                end
            end else begin
                m_force = 1'b0;
                m_cnt   = 0;
            end
        end
        e.we = m_we; e.idx = m_idx; e.data = m_data;
        exp_q.push_back(e);

        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [4:0] s1, input logic [4:0] s2);
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, s1, s2);
    endtask

    task automatic issue(input logic [4:0] rd);
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, rd, 5'd0, 5'd0);
    endtask

    initial begin
        int losses;
        int won;
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
        bus.issue_load = 1'b0; bus.issue_rd = '0; bus.rs1 = '0; bus.rs2 = '0;
        @(posedge clk);
        #1;

        // Reset then idle
        cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        idle(5'd0, 5'd0);
        idle(5'd1, 5'd31);

        // Contention: ALU wins
        cyc(1'b0, 1'b1, 5'd5, 32'hAAAA_0001, 1'b1, 5'd6, 32'hBBBB_0006, 1'b0, 5'd0, 5'd0, 5'd0);
        chk("contend_alu_wins", {30'd0, last_alu_ready, last_mem_ready}, 32'd2);
        idle(5'd0, 5'd0);

        // Starvation: mem loses STARVE_LIMIT cycles then wins once
        issue(5'd7);
        losses = 0;
        won    = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b1, 5'(10 + i), 32'h100 + i, 1'b1, 5'd7, 32'h7777_0007,
                1'b0, 5'd0, 5'd0, 5'd0);
            if (won == 0) begin
                if (last_mem_ready) won = 1;
                else                losses++;
            end
        end
        chk("starve_losses", losses, STARVE_LIMIT);
        chk("starve_alu_after", {31'd0, last_alu_ready}, 32'd1);
        idle(5'd0, 5'd0);

        // MEM_FORCE with mem_valid dropped falls back to ALU
        issue(5'd14);
        for (int i = 0; i < STARVE_LIMIT; i++)
            cyc(1'b0, 1'b1, 5'd2, 32'h2222_0000 + i, 1'b1, 5'd14, 32'hE, 1'b0, 5'd0, 5'd0, 5'd0);
        cyc(1'b0, 1'b1, 5'd3, 32'h3333_3333, 1'b0, 5'd14, 32'hE, 1'b0, 5'd0, 5'd0, 5'd0);
        chk("force_drop_alu", {31'd0, last_alu_ready}, 32'd1);
        cyc(1'b0, 1'b1, 5'd4, 32'h4444_4444, 1'b1, 5'd14, 32'hE, 1'b0, 5'd0, 5'd0, 5'd0);
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd14, 32'hEEEE_000E, 1'b0, 5'd0, 5'd0, 5'd14);
        idle(5'd14, 5'd0);

        // Scoreboard stall across pending and in-flight write
        issue(5'd9);
        idle(5'd9, 5'd0);
        chk("stall_pending", {31'd0, last_stall}, 32'd1);
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h9999_0009, 1'b0, 5'd0, 5'd9, 5'd0);
        idle(5'd9, 5'd0);
        chk("stall_inflight", {31'd0, last_stall}, 32'd1);
        idle(5'd9, 5'd0);
        chk("stall_released", {31'd0, last_stall}, 32'd0);

        // x0 handling
        cyc(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        idle(5'd0, 5'd0);
        issue(5'd0);
        idle(5'd0, 5'd0);
        chk("x0_no_stall", {31'd0, last_stall}, 32'd0);

        // Same-cycle issue and return on one index: set wins, no error
        issue(5'd11);
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'hB0B0_0011, 1'b1, 5'd11, 5'd0, 5'd11);
        idle(5'd0, 5'd11);
        chk("set_wins_stall", {31'd0, last_stall}, 32'd1);
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'hB0B0_0022, 1'b0, 5'd0, 5'd0, 5'd0);
        idle(5'd0, 5'd0);
        chk("no_err_yet", {31'd0, last_err}, 32'd0);

        // Double issue raises a sticky error
        issue(5'd3);
        issue(5'd3);
        idle(5'd0, 5'd0);
        idle(5'd0, 5'd0);
        chk("sb_err_sticky", {31'd0, last_err}, 32'd1);

        // Reset in a cycle with a mem grant
        issue(5'd20);
        cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'h2020_2020, 1'b0, 5'd0, 5'd0, 5'd0);
        idle(5'd20, 5'd0);
        chk("reset_clears_err", {31'd0, last_err}, 32'd0);

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            cyc(($urandom_range(0, 59) == 0),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end
        idle(5'd0, 5'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
